// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage
//
// Instruction-fetch stage of riscv_cpu. Owns the program counter, presents it
// to a combinational instruction memory, and captures the returned word into
// the IF/ID pipeline register for the decode stage.
//
// Ports:
//   clk            - clock, all state changes on the rising edge
//   rst            - synchronous active-high reset
//   stall_i        - hold PC and IF/ID this cycle (hazard logic)
//   flush_i        - replace IF/ID contents with a NOP bubble
//   redirect_i     - load PC from redirect_pc_i (branch / JAL / JALR)
//   redirect_pc_i  - redirect target byte address
//   instr_addr_o   - current PC, to instruction memory
//   instr_data_i   - instruction word at instr_addr_o, same cycle
//   id_pc_o        - PC of the instruction held in IF/ID
//   id_instr_o     - instruction held in IF/ID
//   id_valid_o     - IF/ID holds a real instruction
//   fetch_err_o    - sticky flag, a misaligned redirect target was seen
//   fetch_count_o  - number of valid instructions captured into IF/ID
// ---------------------------------------------------------------------------
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] instr_addr_o,
  input  logic [31:0] instr_data_i,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_instr_o,
  output logic        id_valid_o,
  output logic        fetch_err_o,
  output logic [31:0] fetch_count_o
);

  logic [31:0] pc_q,      pc_d;
  logic [31:0] idPc_q,    idPc_d;
  logic [31:0] idInstr_q, idInstr_d;
  logic        idValid_q, idValid_d;
  logic        err_q,     err_d;
  logic [31:0] count_q,   count_d;

  // Program counter next state. A redirect always wins over a stall, because
  // the redirecting instruction in execute cannot be held back by a hazard
  // in front of it. The low two address bits of the target are dropped so the
  // fetch stays word aligned; a non-zero pair is latched as a sticky error.
  // PC+4 wraps naturally at 2^32.
  always_comb begin
    pc_d  = pc_q;
    err_d = err_q;
    if (redirect_i) begin
      pc_d = {redirect_pc_i[31:2], 2'b00};
      if (redirect_pc_i[1:0] != 2'b00) begin
        err_d = 1'b1;
      end
    end else if (!stall_i) begin
      pc_d = pc_q + 32'd4;
    end
  end

  // IF/ID register next state, decoupled from the PC decision. A flush turns
  // the slot into a bubble but keeps the old PC, so a flush during a stall
  // still kills the held instruction. Only a genuine capture bumps the count.
  always_comb begin
    idPc_d    = idPc_q;
    idInstr_d = idInstr_q;
    idValid_d = idValid_q;
    count_d   = count_q;
    if (flush_i) begin
      idInstr_d = NOP_INSTR;
      idValid_d = 1'b0;
    end else if (!stall_i) begin
      idPc_d    = pc_q;
      idInstr_d = instr_data_i;
      idValid_d = 1'b1;
      count_d   = count_q + 32'd1;
    end
  end

  // State registers. Reset overrides every other input on the same edge, so
  // a redirect presented alongside reset is discarded.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= RESET_PC;
      idPc_q    <= 32'h0000_0000;
      idInstr_q <= NOP_INSTR;
      idValid_q <= 1'b0;
      err_q     <= 1'b0;
      count_q   <= 32'h0000_0000;
    end else begin
      pc_q      <= pc_d;
      idPc_q    <= idPc_d;
      idInstr_q <= idInstr_d;
      idValid_q <= idValid_d;
      err_q     <= err_d;
      count_q   <= count_d;
    end
  end

  assign instr_addr_o  = pc_q;
  assign id_pc_o       = idPc_q;
  assign id_instr_o    = idInstr_q;
  assign id_valid_o    = idValid_q;
  assign fetch_err_o   = err_q;
  assign fetch_count_o = count_q;

endmodule
